// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared encodings for the stopwatch/timer controller.
//               The state encoding is identical to the status output code,
//               so status can be driven straight from the state register.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_ctrl_fsm_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a single-cycle count tick. The phase
//               counter runs 0..TICK_DIV-1 while en is high and holds while
//               en is low, so a pause keeps the sub-tick phase.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               en    - advance the phase counter this cycle
//               clr   - synchronous clear of the phase counter (wins over en)
//               tick  - high in the cycle the phase is TICK_DIV-1 and en set
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A divide-by-one still needs a one-bit counter that simply sits at 0.
    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == TERM);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/timer_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_fsm
// Description : Stopwatch / count-down timer controller: run-control FSM,
//               tick prescaler, time counter and lap capture.
//               Build option TIMER_AUTORELOAD_EN: count-down reloads the
//               value captured at the last start on the 1->0 tick, stays
//               RUNNING and pulses expired for one cycle instead of
//               entering EXPIRED.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               start/stop/reset/lap - single-cycle control pulses
//               mode          - 0 count-up, 1 count-down (sampled on start)
//               load_val      - count-down start value (sampled on start)
//               count_out     - current count
//               lap_val       - last captured lap value
//               lap_valid     - one-cycle pulse when lap_val updates
//               expired       - EXPIRED level (pulse with auto-reload)
//               count_enable  - high while RUNNING
//               status        - 00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
// Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl_fsm #(
    parameter int COUNT_W  = 16,
    parameter int TICK_DIV = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               reset,
    input  logic               lap,
    input  logic               mode,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] count_out,
    output logic [COUNT_W-1:0] lap_val,
    output logic               lap_valid,
    output logic               expired,
    output logic               count_enable,
    output logic [1:0]         status
);

    import timer_pkg::*;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] lap_val_q, lap_val_d;
    logic               lap_valid_q, lap_valid_d;
    logic               mode_q, mode_d;

    logic               presc_en;
    logic               presc_clr;
    logic               tick;
    logic               load_nz;

`ifdef TIMER_AUTORELOAD_EN
    logic [COUNT_W-1:0] reload_q, reload_d;
    logic               expired_q, expired_d;
`endif

    assign load_nz = (load_val != '0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Priority inside one cycle is reset > stop > start; start only acts
    // when neither of the others is present.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mode_d      = mode_q;
        lap_val_d   = lap_val_q;
        lap_valid_d = 1'b0;
        presc_en    = 1'b0;
        presc_clr   = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        reload_d    = reload_q;
        expired_d   = 1'b0;
`endif

        // Lap sees the count as it is this cycle, before any tick update.
        if (lap && (state_q == RUNNING || state_q == PAUSED)) begin
            lap_val_d   = count_q;
            lap_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop && !reset) begin
                    if (mode == MODE_UP) begin
                        count_d   = '0;
                        mode_d    = MODE_UP;
                        presc_clr = 1'b1;
                        state_d   = RUNNING;
                    end else if (load_nz) begin
                        count_d   = load_val;
                        mode_d    = MODE_DOWN;
                        presc_clr = 1'b1;
                        state_d   = RUNNING;
`ifdef TIMER_AUTORELOAD_EN
                        reload_d  = load_val;
`endif
                    end
                end
            end

            RUNNING: begin
                if (reset) begin
                    count_d   = '0;
                    presc_clr = 1'b1;
                    state_d   = IDLE;
                end else if (stop) begin
                    // Prescaler not enabled: the phase is held for resume
                    // and a coincident tick is dropped.
                    state_d = PAUSED;
                end else begin
                    presc_en = 1'b1;
                    if (tick) begin
                        if (mode_q == MODE_UP) begin
                            count_d = count_q + COUNT_W'(1);
                        end else if (count_q == COUNT_W'(1)) begin
`ifdef TIMER_AUTORELOAD_EN
                            count_d   = reload_q;
                            expired_d = 1'b1;
`else
                            count_d   = '0;
                            state_d   = EXPIRED;
`endif
                        end else begin
                            count_d = count_q - COUNT_W'(1);
                        end
                    end
                end
            end

            PAUSED: begin
                if (reset) begin
                    count_d   = '0;
                    presc_clr = 1'b1;
                    state_d   = IDLE;
                end else if (start && !stop) begin
                    state_d = RUNNING;
                end
            end

            EXPIRED: begin
                if (reset) begin
                    count_d   = '0;
                    presc_clr = 1'b1;
                    state_d   = IDLE;
                end else if (start && !stop && load_nz) begin
                    count_d   = load_val;
                    presc_clr = 1'b1;
                    state_d   = RUNNING;
`ifdef TIMER_AUTORELOAD_EN
                    reload_d  = load_val;
`endif
                end
            end

            default: begin
                count_d   = '0;
                presc_clr = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mode_q      <= MODE_UP;
            lap_val_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            lap_val_q   <= lap_val_d;
            lap_valid_q <= lap_valid_d;
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;
`else
    assign expired = (state_q == EXPIRED);
`endif

    assign count_out    = count_q;
    assign lap_val      = lap_val_q;
    assign lap_valid    = lap_valid_q;
    assign count_enable = (state_q == RUNNING);
    assign status       = state_q;

endmodule : timer_ctrl_fsm
`default_nettype wire

// File: tb/tb_timer_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_ctrl_fsm
// Description : Self-checking bench for timer_ctrl_fsm (COUNT_W=8,
//               TICK_DIV=4). Directed scenarios followed by random pulses,
//               all compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl_fsm;

    localparam int COUNT_W  = 8;
    localparam int TICK_DIV = 4;
    localparam int CNT_MOD  = 1 << COUNT_W;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               start, stop, reset, lap, mode;
    logic [COUNT_W-1:0] load_val;
    logic [COUNT_W-1:0] count_out, lap_val;
    logic               lap_valid, expired, count_enable;
    logic [1:0]         status;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: status code, count value, cycles since last tick.
    int m_st, m_cnt, m_ph, m_mode, m_lap, m_lapv, m_pulse, m_reload;

    timer_ctrl_fsm #(
        .COUNT_W  (COUNT_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .reset        (reset),
        .lap          (lap),
        .mode         (mode),
        .load_val     (load_val),
        .count_out    (count_out),
        .lap_val      (lap_val),
        .lap_valid    (lap_valid),
        .expired      (expired),
        .count_enable (count_enable),
        .status       (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_ph = 0; m_mode = 0;
        m_lap = 0; m_lapv = 0; m_pulse = 0; m_reload = 0;
    endtask

    // One clock edge of the specified behaviour, from the inputs present
    // before the edge.
    task automatic model_step();
        int n_st, n_cnt, n_ph;
        n_st = m_st; n_cnt = m_cnt; n_ph = m_ph;
        m_lapv = 0; m_pulse = 0;
        if (lap && (m_st == 1 || m_st == 2)) begin
            m_lap = m_cnt; m_lapv = 1;
        end
        case (m_st)
            0: if (start && !stop && !reset) begin
                if (mode == 1'b0) begin
                    n_cnt = 0; m_mode = 0; n_ph = 0; n_st = 1;
                end else if (load_val != 0) begin
                    n_cnt = int'(load_val); m_mode = 1; n_ph = 0; n_st = 1;
                    m_reload = int'(load_val);
                end
            end
            1: if (reset) begin
                n_st = 0; n_cnt = 0; n_ph = 0;
            end else if (stop) begin
                n_st = 2;
            end else if (m_ph == TICK_DIV - 1) begin
                n_ph = 0;
                if (m_mode == 0) n_cnt = (m_cnt + 1) % CNT_MOD;
                else if (m_cnt == 1) begin
                    if (AUTORELOAD) begin n_cnt = m_reload; m_pulse = 1; end
                    else begin n_cnt = 0; n_st = 3; end
                end else n_cnt = m_cnt - 1;
            end else begin
                n_ph = m_ph + 1;
            end
            2: if (reset) begin
                n_st = 0; n_cnt = 0; n_ph = 0;
            end else if (start && !stop) begin
                n_st = 1;
            end
            default: if (reset) begin
                n_st = 0; n_cnt = 0; n_ph = 0;
            end else if (start && !stop && load_val != 0) begin
                n_cnt = int'(load_val); n_ph = 0; n_st = 1;
                m_reload = int'(load_val);
            end
        endcase
        m_st = n_st; m_cnt = n_cnt; m_ph = n_ph;
    endtask

    task automatic check_all();
        chk("status", 32'(status), m_st);
        chk("count_out", 32'(count_out), m_cnt);
        chk("count_enable", 32'(count_enable), (m_st == 1) ? 1 : 0);
        chk("lap_val", 32'(lap_val), m_lap);
        chk("lap_valid", 32'(lap_valid), m_lapv);
        chk("expired", 32'(expired), AUTORELOAD ? m_pulse : ((m_st == 3) ? 1 : 0));
    endtask

    // Drive one cycle of pulses (called at the falling edge), step the
    // model at the rising edge and compare just after it.
    task automatic cyc(input logic st, input logic sp, input logic rs, input logic lp);
        start = st; stop = sp; reset = rs; lap = lp;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count_out), 0);
        chk({tag, "_lap_val"}, 32'(lap_val), 0);
        chk({tag, "_lap_valid"}, 32'(lap_valid), 0);
        chk({tag, "_expired"}, 32'(expired), 0);
        chk({tag, "_count_enable"}, 32'(count_enable), 0);
        chk({tag, "_status"}, 32'(status), 0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0; lap = 1'b0;
        mode = 1'b0; load_val = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1: count-up start, first tick TICK_DIV cycles after entry
        mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_status_run", 32'(status), 1);
        idle(4);
        chk("t1_count1", 32'(count_out), 1);
        idle(8);
        chk("t1_count3", 32'(count_out), 3);

        // 2: pause at count 5 phase 2, resume keeps the phase
        idle(10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_paused", 32'(status), 2);
        idle(20);
        chk("t2_hold5", 32'(count_out), 5);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t2_still5", 32'(count_out), 5);
        idle(1);
        chk("t2_count6", 32'(count_out), 6);

        // 3: count-down from 3 to expiry, then functional reset
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        mode = 1'b1; load_val = 8'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_load3", 32'(count_out), 3);
        idle(4);
        chk("t3_count2", 32'(count_out), 2);
        idle(4);
        chk("t3_count1", 32'(count_out), 1);
        idle(4);
`ifndef TIMER_AUTORELOAD_EN
        chk("t3_count0", 32'(count_out), 0);
        chk("t3_status_exp", 32'(status), 3);
        chk("t3_expired", 32'(expired), 1);
`endif
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_after_reset", 32'(status), 0);
        chk("t3_expired_clr", 32'(expired), 0);

        // 4: up-count wrap 255 -> 0, then stop coinciding with a tick at 10
        mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1100 && !(m_cnt == 255 && m_ph == TICK_DIV - 1); i++) idle(1);
        idle(1);
        chk("t4_wrap0", 32'(count_out), 0);
        for (int i = 0; i < 100 && !(m_cnt == 10 && m_ph == TICK_DIV - 1); i++) idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_stop_status", 32'(status), 2);
        chk("t4_stop_count", 32'(count_out), 10);

        // 5: lap in the tick cycle at count 7, then lap in IDLE
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100 && !(m_cnt == 7 && m_ph == TICK_DIV - 1); i++) idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_lap_val", 32'(lap_val), 7);
        chk("t5_lap_valid", 32'(lap_valid), 1);
        chk("t5_count8", 32'(count_out), 8);
        idle(1);
        chk("t5_lap_valid_drop", 32'(lap_valid), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_idle_lap", 32'(lap_valid), 0);

        // 6: asynchronous reset in the middle of a run
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400 && m_cnt != 8'h42; i++) idle(1);
        chk("t6_at_42", 32'(count_out), 32'h42);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TIMER_AUTORELOAD_EN
        mode = 1'b1; load_val = 8'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        load_val = 8'd9;
        idle(4);
        chk("t6_ar_1", 32'(count_out), 1);
        idle(4);
        chk("t6_ar_reload", 32'(count_out), 2);
        chk("t6_ar_pulse", 32'(expired), 1);
        chk("t6_ar_status", 32'(status), 1);
        idle(1);
        chk("t6_ar_pulse_end", 32'(expired), 0);
        idle(8);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Random pulse traffic against the model
        for (int i = 0; i < 3000; i++) begin
            mode     = 1'($urandom_range(0, 1));
            load_val = ($urandom_range(0, 7) == 0) ? '0 : COUNT_W'($urandom_range(1, 12));
            if ($urandom_range(0, 499) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                check_reset_outputs("rnd_async");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_timer_ctrl_fsm
`default_nettype wire
